debouncer_botao: RTL and testbench
==================================

Name: debouncer_botao

Overview:
- Debounces one raw asynchronous push-button input. Produces a stable level, single-cycle press and release pulses, and a press counter.
- Sits directly downstream of the system synchronous-reset generator. That generator's active-high output is inverted at top level and drives this block's reset. Its pulses feed the downstream control FSM.
- All state is cleared while the generator holds the system in reset.

Parameters:
N_SINC, 2, number of synchronizer flip-flop stages on botao_in; legal range >= 2
N_ESTAVEL, 4, consecutive synchronized samples required to accept a level change; legal range >= 2
W_CNT, 8, width of contador_press

Ports:
clock  input  1  system clock; all flops are rising-edge triggered
reset  input  1  asynchronous, active-low reset; clears all state immediately
botao_in  input  1  raw button, asynchronous to clock, bouncy, 1 = pressed
botao_estavel  output  1  debounced level, 1 = pressed
pulso_press  output  1  one-cycle pulse when a press is accepted
pulso_solta  output  1  one-cycle pulse when a release is accepted
contador_press  output  W_CNT  number of accepted presses, wrapping

Behaviour:
- Reset (reset = 0):
  - Synchronizer chain, FSM, internal counter and all outputs go to 0 asynchronously.
  - FSM state goes to SOLTO.
  - Outputs stay 0 while reset is low.
- Synchronizer: botao_in passes through N_SINC flops, giving s. No other logic samples botao_in.
- Internal counter cnt: width ceil(log2(N_ESTAVEL)), minimum 1.
- FSM states and transitions, each evaluated on every rising edge:
  - SOLTO: if s = 1, go to CONF_PRESS with cnt = 1. Otherwise stay.
  - CONF_PRESS:
    - If s = 0, go to SOLTO with cnt = 0 (bounce rejected, no output change).
    - Else if cnt = N_ESTAVEL-1, go to PRESSIONADO with cnt = 0, botao_estavel <= 1, pulso_press <= 1, contador_press <= contador_press + 1.
    - Else cnt <= cnt + 1.
  - PRESSIONADO: if s = 0, go to CONF_SOLTA with cnt = 1. Otherwise stay.
  - CONF_SOLTA:
    - If s = 1, go to PRESSIONADO with cnt = 0.
    - Else if cnt = N_ESTAVEL-1, go to SOLTO with cnt = 0, botao_estavel <= 0, pulso_solta <= 1.
    - Else cnt <= cnt + 1.
- Outputs:
  - All outputs are registered; none is combinational from any input.
  - pulso_press and pulso_solta default to 0 every cycle and are 1 for exactly one cycle per accepted transition.
  - The two pulses are never high in the same cycle.
- Latency:
  - Count the first rising edge that captures a new botao_in level as edge 1.
  - If that level is held stable, botao_estavel and the matching pulse become 1 after edge N_SINC+N_ESTAVEL. With defaults, that is edge 6.
- Bounce rejection: any level that is not held for N_ESTAVEL consecutive synchronized samples produces no output change and no pulse.
- contador_press: increments by 1 per accepted press and wraps from 2^W_CNT-1 to 0. No saturation and no flag.
- Reset mid-operation:
  - Asserting reset in any state aborts that state. Outputs are 0 at once.
  - A pulse in flight is dropped.
  - contador_press returns to 0.
- Button held through reset release: this is treated as a new press. Exactly one pulso_press is generated N_SINC+N_ESTAVEL edges after the first edge following release.
- No illegal states: any unreachable encoding returns to SOLTO on the next edge.

Test Plan:
- Reset hold: reset = 0 for 10 cycles while botao_in toggles every cycle -> all outputs 0 throughout, contador_press = 0.
- Clean press (defaults): botao_in 0->1 and held 12 cycles after reset release -> botao_estavel = 1 and pulso_press = 1 after edge 6, pulso_press = 0 after edge 7, contador_press = 1, pulso_solta never 1.
- Bounce rejection: botao_in = 1 for 3 cycles, 0 for 2, 1 for 3, then 0 held -> no pulse, botao_estavel = 0, contador_press = 0.
- Clean release with release bounce: after an accepted press, botao_in = 0 for 2 cycles, 1 for 1, then 0 held -> exactly one pulso_solta, 6 edges after the final 0 is captured, then botao_estavel = 0, contador_press still 1.
- Wrap: 256 clean press/release cycles, each level held 8 cycles -> 256 pulso_press pulses, contador_press = 255 after the 255th and 0 after the 256th.
- Reset mid-confirmation: press held, reset = 0 asserted between edges 4 and 5, released 3 cycles later with botao_in still 1 -> outputs 0 immediately, no pulse before release, one pulso_press 6 edges after release, contador_press = 1.

Source files
------------

// File: rtl/debouncer_botao.sv
// Push-button debouncer: N_SINC-stage synchronizer, then a confirm FSM that needs N_ESTAVEL equal samples.
// Latency: N_SINC+N_ESTAVEL edges from capture to registered level/pulse; no backpressure, pulses are single-cycle.
module debouncer_botao #(
  parameter int N_SINC    = 2,
  parameter int N_ESTAVEL = 4,
  parameter int W_CNT     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             botao_in,
  output logic             botao_estavel,
  output logic             pulso_press,
  output logic             pulso_solta,
  output logic [W_CNT-1:0] contador_press
);

  localparam int W_C = ($clog2(N_ESTAVEL) < 1) ? 1 : $clog2(N_ESTAVEL);
  localparam logic [W_C-1:0] CNT_FIM = W_C'(N_ESTAVEL - 1);
  localparam logic [W_C-1:0] CNT_UM  = W_C'(1);

  typedef enum logic [1:0] {
    SOLTO       = 2'd0,
    CONF_PRESS  = 2'd1,
    PRESSIONADO = 2'd2,
    CONF_SOLTA  = 2'd3
  } estado_t;

  logic [N_SINC-1:0] sinc_q;
  logic              s;

  estado_t           estado_q, estado_d;
  logic [W_C-1:0]    cnt_q, cnt_d;
  logic              estavel_q, estavel_d;
  logic              press_q, press_d;
  logic              solta_q, solta_d;
  logic [W_CNT-1:0]  contador_q, contador_d;

  // botao_in is only ever sampled by the first flop of this chain.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sinc_q <= '0;
    end else begin
      sinc_q <= {sinc_q[N_SINC-2:0], botao_in};
    end
  end

  assign s = sinc_q[N_SINC-1];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q   <= SOLTO;
      cnt_q      <= '0;
      estavel_q  <= 1'b0;
      press_q    <= 1'b0;
      solta_q    <= 1'b0;
      contador_q <= '0;
    end else begin
      estado_q   <= estado_d;
      cnt_q      <= cnt_d;
      estavel_q  <= estavel_d;
      press_q    <= press_d;
      solta_q    <= solta_d;
      contador_q <= contador_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    cnt_d      = cnt_q;
    estavel_d  = estavel_q;
    press_d    = 1'b0;
    solta_d    = 1'b0;
    contador_d = contador_q;

    case (estado_q)
      SOLTO: begin
        if (s) begin
          estado_d = CONF_PRESS;
          cnt_d    = CNT_UM;
        end
      end

      CONF_PRESS: begin
        if (!s) begin
          estado_d = SOLTO;
          cnt_d    = '0;
        end else if (cnt_q == CNT_FIM) begin
          estado_d   = PRESSIONADO;
          cnt_d      = '0;
          estavel_d  = 1'b1;
          press_d    = 1'b1;
          contador_d = contador_q + W_CNT'(1);
        end else begin
          cnt_d = cnt_q + CNT_UM;
        end
      end

      PRESSIONADO: begin
        if (!s) begin
          estado_d = CONF_SOLTA;
          cnt_d    = CNT_UM;
        end
      end

      CONF_SOLTA: begin
        if (s) begin
          estado_d = PRESSIONADO;
          cnt_d    = '0;
        end else if (cnt_q == CNT_FIM) begin
          estado_d  = SOLTO;
          cnt_d     = '0;
          estavel_d = 1'b0;
          solta_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_UM;
        end
      end

      default: begin
        estado_d = SOLTO;
        cnt_d    = '0;
      end
    endcase
  end

  assign botao_estavel  = estavel_q;
  assign pulso_press    = press_q;
  assign pulso_solta    = solta_q;
  assign contador_press = contador_q;

endmodule

// File: tb/tb_debouncer_botao.sv
// Bench for debouncer_botao: directed scenarios plus random bursts against a sliding-window reference model.
module tb_debouncer_botao;
  localparam int N_SINC    = 2;
  localparam int N_ESTAVEL = 4;
  localparam int W_CNT     = 8;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic             botao_in = 1'b0;
  logic             botao_estavel;
  logic             pulso_press;
  logic             pulso_solta;
  logic [W_CNT-1:0] contador_press;

  int total = 0;
  int bad   = 0;

  // Reference model: raw samples since reset, window of the last N_ESTAVEL synchronized samples.
  bit               hist[$];
  bit               win[$];
  bit               m_est, m_press, m_solta;
  logic [W_CNT-1:0] m_cnt;

  debouncer_botao #(
    .N_SINC   (N_SINC),
    .N_ESTAVEL(N_ESTAVEL),
    .W_CNT    (W_CNT)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .botao_in      (botao_in),
    .botao_estavel (botao_estavel),
    .pulso_press   (pulso_press),
    .pulso_solta   (pulso_solta),
    .contador_press(contador_press)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic model_clear();
    hist.delete();
    win.delete();
    m_est   = 1'b0;
    m_press = 1'b0;
    m_solta = 1'b0;
    m_cnt   = '0;
  endtask

  // A level flips when all of the last N_ESTAVEL synchronized samples disagree with it.
  task automatic model_edge(input bit b);
    bit s;
    bit flip;
    hist.push_back(b);
    s = (hist.size() > N_SINC) ? hist[hist.size()-1-N_SINC] : 1'b0;
    if (hist.size() > N_SINC + 1) void'(hist.pop_front());
    win.push_back(s);
    if (win.size() > N_ESTAVEL) void'(win.pop_front());
    m_press = 1'b0;
    m_solta = 1'b0;
    flip = (win.size() == N_ESTAVEL);
    foreach (win[i]) if (win[i] == m_est) flip = 1'b0;
    if (flip) begin
      m_est = !m_est;
      if (m_est) begin
        m_press = 1'b1;
        m_cnt   = m_cnt + 1'b1;
      end else begin
        m_solta = 1'b1;
      end
    end
  endtask

  task automatic step(input bit b);
    botao_in = b;
    @(posedge clock);
    model_edge(b);
    #1;
  endtask

  task automatic release_reset();
    @(negedge clock);
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    total++;
    if ({botao_estavel, pulso_press, pulso_solta, contador_press} !== '0) begin
      bad++;
      $display("FAIL reset_initial: got est=%0b press=%0b solta=%0b cnt=%0d, want all 0",
               botao_estavel, pulso_press, pulso_solta, contador_press);
    end
    for (int k = 0; k < 10; k++) begin
      botao_in = k[0];
      @(posedge clock);
      #1;
      total++;
      if ({botao_estavel, pulso_press, pulso_solta, contador_press} !== '0) begin
        bad++;
        $display("FAIL reset_hold[%0d]: got est=%0b press=%0b solta=%0b cnt=%0d, want all 0",
                 k, botao_estavel, pulso_press, pulso_solta, contador_press);
      end
    end
    botao_in = 1'b0;
    release_reset();
  endtask

  task automatic test_bounce();
    int lv[4]  = '{1, 0, 1, 0};
    int dur[4] = '{3, 2, 3, 12};
    int pulses = 0;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < dur[p]; k++) begin
        step(lv[p][0]);
        if (pulso_press || pulso_solta) pulses++;
        total++;
        if ({botao_estavel, pulso_press, pulso_solta, contador_press} !== {m_est, m_press, m_solta, m_cnt}) begin
          bad++;
          $display("FAIL bounce_model: got %0b %0b %0b %0d, want %0b %0b %0b %0d",
                   botao_estavel, pulso_press, pulso_solta, contador_press, m_est, m_press, m_solta, m_cnt);
        end
      end
    end
    total++;
    if (pulses != 0 || botao_estavel !== 1'b0 || contador_press !== 8'd0) begin
      bad++;
      $display("FAIL bounce_reject: got pulses=%0d est=%0b cnt=%0d, want 0 0 0",
               pulses, botao_estavel, contador_press);
    end
  endtask

  task automatic test_clean_press();
    int first = -1;
    for (int k = 1; k <= 12; k++) begin
      step(1'b1);
      if (pulso_press && first < 0) first = k;
      total++;
      if ({botao_estavel, pulso_press, pulso_solta, contador_press} !== {m_est, m_press, m_solta, m_cnt}) begin
        bad++;
        $display("FAIL press_model[%0d]: got %0b %0b %0b %0d, want %0b %0b %0b %0d", k,
                 botao_estavel, pulso_press, pulso_solta, contador_press, m_est, m_press, m_solta, m_cnt);
      end
      total++;
      if (pulso_solta !== 1'b0 || botao_estavel !== (k >= 6) || pulso_press !== (k == 6)) begin
        bad++;
        $display("FAIL press_edge[%0d]: got est=%0b press=%0b solta=%0b, want est=%0b press=%0b solta=0",
                 k, botao_estavel, pulso_press, pulso_solta, k >= 6, k == 6);
      end
    end
    total++;
    if (first != 6 || contador_press !== 8'd1) begin
      bad++;
      $display("FAIL press_latency: got edge=%0d cnt=%0d, want edge=6 cnt=1", first, contador_press);
    end
  endtask

  task automatic test_release_bounce();
    bit pre[3] = '{0, 0, 1};
    int pulses = 0;
    int at = -1;
    for (int k = 0; k < 3; k++) begin
      step(pre[k]);
      if (pulso_solta) pulses++;
    end
    for (int k = 1; k <= 10; k++) begin
      step(1'b0);
      if (pulso_solta) begin
        pulses++;
        at = k;
      end
      total++;
      if ({botao_estavel, pulso_press, pulso_solta, contador_press} !== {m_est, m_press, m_solta, m_cnt}) begin
        bad++;
        $display("FAIL release_model[%0d]: got %0b %0b %0b %0d, want %0b %0b %0b %0d", k,
                 botao_estavel, pulso_press, pulso_solta, contador_press, m_est, m_press, m_solta, m_cnt);
      end
    end
    total++;
    if (pulses != 1 || at != 6 || botao_estavel !== 1'b0 || contador_press !== 8'd1) begin
      bad++;
      $display("FAIL release_bounce: got pulses=%0d edge=%0d est=%0b cnt=%0d, want 1 6 0 1",
               pulses, at, botao_estavel, contador_press);
    end
  endtask

  task automatic test_random();
    int n = 0;
    while (n < 400) begin
      bit lvl = 1'($urandom_range(0, 1));
      int d   = $urandom_range(1, 7);
      for (int k = 0; k < d; k++) begin
        step(lvl);
        n++;
        total++;
        if ({botao_estavel, pulso_press, pulso_solta, contador_press} !== {m_est, m_press, m_solta, m_cnt}) begin
          bad++;
          $display("FAIL random_model[%0d]: got %0b %0b %0b %0d, want %0b %0b %0b %0d", n,
                   botao_estavel, pulso_press, pulso_solta, contador_press, m_est, m_press, m_solta, m_cnt);
        end
        if (pulso_press && pulso_solta) begin
          bad++;
          $display("FAIL random_both_pulses[%0d]: got press=1 solta=1, want at most one", n);
        end
      end
    end
  endtask

  task automatic test_wrap();
    int presses = 0;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    release_reset();
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 16; k++) begin
        step(k < 8);
        if (pulso_press) begin
          presses++;
          if (presses == 255) begin
            total++;
            if (contador_press !== 8'd255) begin
              bad++;
              $display("FAIL wrap_255: got cnt=%0d, want 255", contador_press);
            end
          end
        end
        total++;
        if ({botao_estavel, pulso_press, pulso_solta, contador_press} !== {m_est, m_press, m_solta, m_cnt}) begin
          bad++;
          $display("FAIL wrap_model[%0d.%0d]: got %0b %0b %0b %0d, want %0b %0b %0b %0d", i, k,
                   botao_estavel, pulso_press, pulso_solta, contador_press, m_est, m_press, m_solta, m_cnt);
        end
      end
    end
    total++;
    if (presses != 256 || contador_press !== 8'd0) begin
      bad++;
      $display("FAIL wrap_end: got presses=%0d cnt=%0d, want 256 0", presses, contador_press);
    end
  endtask

  task automatic test_reset_mid();
    int at = -1;
    int pulses = 0;
    for (int k = 0; k < 16; k++) step(k < 8);
    for (int k = 1; k <= 4; k++) step(1'b1);
    #2;
    reset = 1'b0;
    #1;
    total++;
    if ({botao_estavel, pulso_press, pulso_solta, contador_press} !== '0) begin
      bad++;
      $display("FAIL reset_mid_async: got est=%0b press=%0b solta=%0b cnt=%0d, want all 0",
               botao_estavel, pulso_press, pulso_solta, contador_press);
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clock);
      #1;
      total++;
      if ({botao_estavel, pulso_press, pulso_solta, contador_press} !== '0) begin
        bad++;
        $display("FAIL reset_mid_hold[%0d]: got est=%0b press=%0b solta=%0b cnt=%0d, want all 0",
                 k, botao_estavel, pulso_press, pulso_solta, contador_press);
      end
    end
    release_reset();
    for (int k = 1; k <= 10; k++) begin
      step(1'b1);
      if (pulso_press) begin
        pulses++;
        at = k;
      end
      total++;
      if ({botao_estavel, pulso_press, pulso_solta, contador_press} !== {m_est, m_press, m_solta, m_cnt}) begin
        bad++;
        $display("FAIL reset_mid_model[%0d]: got %0b %0b %0b %0d, want %0b %0b %0b %0d", k,
                 botao_estavel, pulso_press, pulso_solta, contador_press, m_est, m_press, m_solta, m_cnt);
      end
    end
    total++;
    if (pulses != 1 || at != 6 || contador_press !== 8'd1) begin
      bad++;
      $display("FAIL reset_mid_press: got pulses=%0d edge=%0d cnt=%0d, want 1 6 1",
               pulses, at, contador_press);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_bounce();
    test_clean_press();
    test_release_bounce();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
